mvma_par: RTL and testbench

MVMA_PAR -- requirements
Module: mvma_par

---
 rtl/mvma_par_if.sv | 25 ++
 rtl/mvma_par.sv | 235 +++++++++++++++++++++++
 tb/tb_mvma_par.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mvma_par_if.sv
// Streaming interface for mvma_par: element input stream and result output stream.
interface mvma_par_if #(
  parameter int DW  = 8,
  parameter int ODW = 16
) ();
  logic                  s_valid;
  logic                  s_ready;
  logic signed [DW-1:0]  data_in;
  logic                  m_valid;
  logic                  m_ready;
  logic signed [ODW-1:0] data_out;
  logic                  overflow;

  // Producer/consumer side (drives inputs, observes results)
  modport master (
    output s_valid, data_in, m_ready,
    input  s_ready, m_valid, data_out, overflow
  );

  // Block side
  modport slave (
    input  s_valid, data_in, m_ready,
    output s_ready, m_valid, data_out, overflow
  );
endinterface

// File: rtl/mvma_par.sv
// mvma_par: streamed matrix-vector multiply-add y = A*x + b.
// A (row-major), x and b are loaded one element per accepted beat, then rows
// are computed LANES at a time (one MAC per lane per cycle, then the bias add)
// and drained one result per output handshake in ascending row order.
module mvma_par #(
  parameter int M     = 4,
  parameter int N     = 4,
  parameter int LANES = 2,
  parameter int DW    = 8,
  parameter int ODW   = 16,
  parameter int SAT   = 0
) (
  input  logic       clk,
  input  logic       reset,
  mvma_par_if.slave  bus
);

  localparam int G   = M / LANES;
  localparam int PW  = 2 * DW;
  localparam int AW  = (M * N > 1) ? $clog2(M * N) : 1;
  localparam int XW  = (N > 1) ? $clog2(N) : 1;
  localparam int BW  = (M > 1) ? $clog2(M) : 1;
  localparam int KW  = $clog2(N + 1);
  localparam int GW  = (G > 1) ? $clog2(G) : 1;
  localparam int LW  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam bit SAT_EN = (SAT != 0);
  localparam logic [ODW-1:0] SAT_MAX = {1'b0, {(ODW-1){1'b1}}};
  localparam logic [ODW-1:0] SAT_MIN = {1'b1, {(ODW-1){1'b0}}};

  if ((M % LANES) != 0) begin : g_bad_lanes
    $error("mvma_par: M must be a multiple of LANES");
  end
  if (ODW < 2 * DW) begin : g_bad_odw
    $error("mvma_par: ODW must be at least 2*DW");
  end

  typedef enum logic [2:0] {
    ST_LOAD_A  = 3'd0,
    ST_LOAD_X  = 3'd1,
    ST_LOAD_B  = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  // Adds addend to an accumulator at ODW bits. Returns {overflow, value}.
  // Overflow is sticky; in saturating mode a row that has clamped stays clamped.
  function automatic logic [ODW:0] acc_add(
    input logic signed [ODW-1:0] acc,
    input logic                  ovf_in,
    input logic signed [ODW-1:0] addend
  );
    logic [ODW:0]   sum;
    logic           step_ovf;
    logic [ODW-1:0] res;
    sum      = {acc[ODW-1], acc} + {addend[ODW-1], addend};
    step_ovf = sum[ODW] ^ sum[ODW-1];
    if (SAT_EN && ovf_in) begin
      res = acc;
    end else if (SAT_EN && step_ovf) begin
      res = sum[ODW] ? SAT_MIN : SAT_MAX;
    end else begin
      res = sum[ODW-1:0];
    end
    return {ovf_in | step_ovf, res};
  endfunction

  state_t                state_r;
  logic [AW-1:0]         cnt_r;
  logic [KW-1:0]         k_r;
  logic [GW-1:0]         grp_r;
  logic [LW-1:0]         lane_idx_r;
  logic                  s_ready_r;
  logic                  m_valid_r;
  logic signed [ODW-1:0] data_out_r;
  logic                  overflow_r;

  logic signed [DW-1:0]  a_mem_r [M*N];
  logic signed [DW-1:0]  x_mem_r [N];
  logic signed [DW-1:0]  b_mem_r [M];

  logic signed [ODW-1:0] acc_r      [LANES];
  logic                  ovf_r      [LANES];
  logic signed [ODW-1:0] obuf_r     [LANES];
  logic                  obuf_ovf_r [LANES];

  logic signed [PW-1:0]  prod_s     [LANES];
  logic signed [ODW-1:0] add_s      [LANES];
  logic [ODW:0]          res_s      [LANES];
  logic signed [ODW-1:0] step_val_s [LANES];
  logic                  step_ovf_s [LANES];
  logic                  accept_s;

  assign accept_s     = bus.s_valid & s_ready_r;
  assign bus.s_ready  = s_ready_r;
  assign bus.m_valid  = m_valid_r;
  assign bus.data_out = data_out_r;
  assign bus.overflow = overflow_r;

  // Per-lane next accumulator: MAC term for steps 0..N-1, bias on step N
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      prod_s[l] = PW'(a_mem_r[AW'((int'(grp_r) * LANES + l) * N + int'(k_r))])
                * PW'(x_mem_r[XW'(k_r)]);
      add_s[l]  = (k_r == KW'(N)) ? ODW'(b_mem_r[BW'(int'(grp_r) * LANES + l)])
                                  : ODW'(prod_s[l]);
      res_s[l]      = acc_add(acc_r[l], ovf_r[l], add_s[l]);
      step_ovf_s[l] = res_s[l][ODW];
      step_val_s[l] = res_s[l][ODW-1:0];
    end
  end

  // Operand memories: each accepted element lands at the load counter position
  always_ff @(posedge clk) begin
    if (accept_s) begin
      case (state_r)
        ST_LOAD_A: a_mem_r[cnt_r]      <= bus.data_in;
        ST_LOAD_X: x_mem_r[XW'(cnt_r)] <= bus.data_in;
        ST_LOAD_B: b_mem_r[BW'(cnt_r)] <= bus.data_in;
        default:   ;
      endcase
    end
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_LOAD_A;
      cnt_r      <= '0;
      k_r        <= '0;
      grp_r      <= '0;
      lane_idx_r <= '0;
      s_ready_r  <= 1'b1;
      m_valid_r  <= 1'b0;
      data_out_r <= '0;
      overflow_r <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        acc_r[l]      <= '0;
        ovf_r[l]      <= 1'b0;
        obuf_r[l]     <= '0;
        obuf_ovf_r[l] <= 1'b0;
      end
    end else begin
      case (state_r)
        ST_LOAD_A: begin
          if (accept_s) begin
            if (cnt_r == AW'(M * N - 1)) begin
              cnt_r   <= '0;
              state_r <= ST_LOAD_X;
            end else begin
              cnt_r <= cnt_r + AW'(1);
            end
          end
        end
        ST_LOAD_X: begin
          if (accept_s) begin
            if (cnt_r == AW'(N - 1)) begin
              cnt_r   <= '0;
              state_r <= ST_LOAD_B;
            end else begin
              cnt_r <= cnt_r + AW'(1);
            end
          end
        end
        ST_LOAD_B: begin
          if (accept_s) begin
            if (cnt_r == AW'(M - 1)) begin
              cnt_r     <= '0;
              k_r       <= '0;
              grp_r     <= '0;
              s_ready_r <= 1'b0;
              state_r   <= ST_COMPUTE;
              for (int l = 0; l < LANES; l++) begin
                acc_r[l] <= '0;
                ovf_r[l] <= 1'b0;
              end
            end else begin
              cnt_r <= cnt_r + AW'(1);
            end
          end
        end
        ST_COMPUTE: begin
          for (int l = 0; l < LANES; l++) begin
            acc_r[l] <= step_val_s[l];
            ovf_r[l] <= step_ovf_s[l];
          end
          if (k_r == KW'(N)) begin
            // Bias step: latch the whole group and present its first row
            for (int l = 0; l < LANES; l++) begin
              obuf_r[l]     <= step_val_s[l];
              obuf_ovf_r[l] <= step_ovf_s[l];
            end
            data_out_r <= step_val_s[0];
            overflow_r <= step_ovf_s[0];
            m_valid_r  <= 1'b1;
            lane_idx_r <= '0;
            state_r    <= ST_DRAIN;
          end else begin
            k_r <= k_r + KW'(1);
          end
        end
        ST_DRAIN: begin
          if (bus.m_ready) begin
            if (lane_idx_r == LW'(LANES - 1)) begin
              m_valid_r <= 1'b0;
              if (grp_r == GW'(G - 1)) begin
                s_ready_r <= 1'b1;
                cnt_r     <= '0;
                state_r   <= ST_LOAD_A;
              end else begin
                grp_r   <= grp_r + GW'(1);
                k_r     <= '0;
                state_r <= ST_COMPUTE;
                for (int l = 0; l < LANES; l++) begin
                  acc_r[l] <= '0;
                  ovf_r[l] <= 1'b0;
                end
              end
            end else begin
              lane_idx_r <= lane_idx_r + LW'(1);
              data_out_r <= obuf_r[lane_idx_r + LW'(1)];
              overflow_r <= obuf_ovf_r[lane_idx_r + LW'(1)];
            end
          end
        end
        default: begin
          state_r   <= ST_LOAD_A;
          cnt_r     <= '0;
          s_ready_r <= 1'b1;
          m_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mvma_par.sv
// Bench for mvma_par: two instances (wrap and saturate) share one stimulus
// stream; a queue-based model of y = A*x + b supplies expected results.
module tb_mvma_par;
  localparam int M = 4, N = 4, LANES = 2, DW = 8, ODW = 16;
  localparam int TOTAL = M * N + N + M;
  localparam longint OMAX = (longint'(1) <<< (ODW - 1)) - longint'(1);
  localparam longint OMIN = -(longint'(1) <<< (ODW - 1));

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic s_valid = 1'b0;
  logic m_ready = 1'b1;
  logic signed [DW-1:0] data_in = '0;

  int errors = 0;
  int checks = 0;

  int pa [M*N];
  int px [N];
  int pb [M];

  longint exp_v0[$], exp_v1[$];
  bit     exp_o0[$], exp_o1[$];
  longint got0[$], got1[$];
  longint lit0[$], lit1[$];

  int     cyc = 0;
  int     in_cnt = 0, out_cnt = 0;
  bit     busy = 1'b0, mv_prev = 1'b0, stall_prev = 1'b0;
  int     ref_cyc = 0, last_final_cyc = 0, b2b_gap = -1;
  longint hold_d0, hold_d1;
  bit     hold_o0, hold_o1;

  always #5 clk = ~clk;

  mvma_par_if #(.DW(DW), .ODW(ODW)) if0 ();
  mvma_par_if #(.DW(DW), .ODW(ODW)) if1 ();

  assign if0.s_valid = s_valid;
  assign if0.data_in = data_in;
  assign if0.m_ready = m_ready;
  assign if1.s_valid = s_valid;
  assign if1.data_in = data_in;
  assign if1.m_ready = m_ready;

  mvma_par #(.M(M), .N(N), .LANES(LANES), .DW(DW), .ODW(ODW), .SAT(0)) dut0 (
    .clk(clk), .reset(reset), .bus(if0));
  mvma_par #(.M(M), .N(N), .LANES(LANES), .DW(DW), .ODW(ODW), .SAT(1)) dut1 (
    .clk(clk), .reset(reset), .bus(if1));

  task automatic chk(input string name, input longint got, input longint expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  function automatic longint wrap(input longint s);
    longint m, w;
    m = longint'(1) <<< ODW;
    w = s % m;
    if (w < 0) w += m;
    if (w > OMAX) w -= m;
    return w;
  endfunction

  // Exact-arithmetic reference for one row
  task automatic model_row(input int row, input bit sat, output longint val, output bit ovf);
    longint s, cv;
    bit clamped;
    s = 0; cv = 0; ovf = 1'b0; clamped = 1'b0;
    for (int j = 0; j <= N; j++) begin
      if (j < N) s += longint'(pa[row*N + j]) * longint'(px[j]);
      else       s += longint'(pb[row]);
      if (!clamped && (s > OMAX || s < OMIN)) begin
        ovf = 1'b1; clamped = 1'b1; cv = (s > OMAX) ? OMAX : OMIN;
      end
    end
    val = (sat && clamped) ? cv : wrap(s);
  endtask

  task automatic set_problem(input int kind);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        case (kind)
          0: pa[i*N+j] = (i == j) ? 1 : 0;
          1: pa[i*N+j] = 127;
          2: pa[i*N+j] = -128;
          default: pa[i*N+j] = (i == j) ? 2 : 0;
        endcase
    for (int j = 0; j < N; j++)
      px[j] = (kind == 0) ? j + 1 : (kind == 1) ? 127 : (kind == 2) ? -128 : 1;
    for (int i = 0; i < M; i++)
      pb[i] = (kind == 0) ? 10 * (i + 1) : (kind == 1) ? 127 : 0;
  endtask

  task automatic push_expected();
    longint v; bit o;
    for (int r = 0; r < M; r++) begin
      model_row(r, 1'b0, v, o); exp_v0.push_back(v); exp_o0.push_back(o);
      model_row(r, 1'b1, v, o); exp_v1.push_back(v); exp_o1.push_back(o);
    end
  endtask

  task automatic send(input int v, input bit gappy);
    int guard;
    if (gappy && $urandom_range(0, 1) == 1) begin
      s_valid = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    data_in = DW'(v);
    guard = 0;
    while (!if0.s_ready && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 300) chk("send_timeout", guard, 0);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic stream(input bit gappy);
    for (int i = 0; i < M * N; i++) send(pa[i], gappy);
    for (int j = 0; j < N; j++) send(px[j], gappy);
    for (int i = 0; i < M; i++) send(pb[i], gappy);
    s_valid = 1'b0;
  endtask

  task automatic wait_drained();
    int guard = 0;
    while (exp_v0.size() != 0 && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 500) chk("drain_timeout", exp_v0.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_got(input int n);
    int guard = 0;
    while (got0.size() < n && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 500) chk("wait_got_timeout", got0.size(), n);
  endtask

  task automatic lits(input longint a0, b0, c0, d0, input longint a1, b1, c1, d1);
    lit0.push_back(a0); lit0.push_back(b0); lit0.push_back(c0); lit0.push_back(d0);
    lit1.push_back(a1); lit1.push_back(b1); lit1.push_back(c1); lit1.push_back(d1);
  endtask

  task automatic check_lits(input string nm);
    chk({nm, "_count"}, got0.size(), lit0.size());
    for (int i = 0; i < lit0.size() && i < got0.size(); i++) begin
      chk($sformatf("%s_wrap_y%0d", nm, i), got0[i], lit0[i]);
      chk($sformatf("%s_sat_y%0d", nm, i), got1[i], lit1[i]);
    end
    lit0.delete(); lit1.delete(); got0.delete(); got1.delete();
  endtask

  // Cycle monitor: handshake timing, stall stability and scoreboard compare
  always @(negedge clk) begin
    longint ev0, ev1;
    bit eo0, eo1;
    cyc++;
    if (reset) begin
      exp_v0.delete(); exp_v1.delete(); exp_o0.delete(); exp_o1.delete();
      got0.delete(); got1.delete();
      busy = 1'b0; in_cnt = 0; out_cnt = 0; stall_prev = 1'b0; mv_prev = 1'b0;
    end else begin
      chk("s_ready_wrap", if0.s_ready, !busy);
      chk("s_ready_sat", if1.s_ready, !busy);
      if (!busy) begin
        chk("m_valid_idle_wrap", if0.m_valid, 0);
        chk("m_valid_idle_sat", if1.m_valid, 0);
      end
      if (stall_prev) begin
        chk("stall_valid", if0.m_valid, 1);
        chk("stall_data_wrap", if0.data_out, hold_d0);
        chk("stall_ovf_wrap", if0.overflow, hold_o0);
        chk("stall_data_sat", if1.data_out, hold_d1);
        chk("stall_ovf_sat", if1.overflow, hold_o1);
      end
      if (if0.m_valid && !mv_prev) chk("group_latency", cyc - ref_cyc, N + 2);
      if (s_valid && if0.s_ready) begin
        in_cnt++;
        if (in_cnt == 1) b2b_gap = cyc - last_final_cyc;
        if (in_cnt == TOTAL) begin
          in_cnt = 0; busy = 1'b1; ref_cyc = cyc;
        end
      end
      if (if0.m_valid && m_ready) begin
        if (exp_v0.size() == 0) begin
          chk("unexpected_output", exp_v0.size(), 1);
        end else begin
          ev0 = exp_v0.pop_front(); eo0 = exp_o0.pop_front();
          ev1 = exp_v1.pop_front(); eo1 = exp_o1.pop_front();
          chk("data_out_wrap", if0.data_out, ev0);
          chk("overflow_wrap", if0.overflow, eo0);
          chk("m_valid_sat", if1.m_valid, 1);
          chk("data_out_sat", if1.data_out, ev1);
          chk("overflow_sat", if1.overflow, eo1);
        end
        got0.push_back(if0.data_out);
        got1.push_back(if1.data_out);
        out_cnt++;
        if (out_cnt % LANES == 0) ref_cyc = cyc;
        if (out_cnt == M) begin
          out_cnt = 0; busy = 1'b0; last_final_cyc = cyc;
        end
      end
      stall_prev = if0.m_valid && !m_ready;
      hold_d0 = if0.data_out; hold_o0 = if0.overflow;
      hold_d1 = if1.data_out; hold_o1 = if1.overflow;
      mv_prev = if0.m_valid;
    end
  end

  // Directed scenario sequence
  initial begin
    longint v; bit o;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_s_ready", if0.s_ready, 1);
    chk("rst_m_valid", if0.m_valid, 0);
    chk("rst_data_out", if0.data_out, 0);
    chk("rst_overflow", if0.overflow, 0);
    chk("rst_sat_data_out", if1.data_out, 0);

    // Hand-computed values pinning the reference model
    set_problem(0);
    model_row(0, 1'b0, v, o); chk("model_id_y0", v, 11); chk("model_id_o0", o, 0);
    model_row(3, 1'b0, v, o); chk("model_id_y3", v, 44);
    set_problem(1);
    model_row(0, 1'b0, v, o); chk("model_127_wrap", v, -893); chk("model_127_ovf", o, 1);
    model_row(2, 1'b1, v, o); chk("model_127_sat", v, 32767);
    set_problem(2);
    model_row(1, 1'b0, v, o); chk("model_m128_wrap", v, 0); chk("model_m128_ovf", o, 1);
    model_row(1, 1'b1, v, o); chk("model_m128_sat", v, 32767);

    // Identity problem, continuous stream
    set_problem(0); push_expected(); stream(1'b0); wait_drained();
    lits(11, 22, 33, 44, 11, 22, 33, 44); check_lits("identity");

    // All 127: wraps / saturates with overflow
    set_problem(1); push_expected(); stream(1'b0); wait_drained();
    lits(-893, -893, -893, -893, 32767, 32767, 32767, 32767); check_lits("all127");

    // All -128, b = 0
    set_problem(2); push_expected(); stream(1'b0); wait_drained();
    lits(0, 0, 0, 0, 32767, 32767, 32767, 32767); check_lits("allm128");

    // Gappy input and a 5-cycle output stall mid-drain
    set_problem(0); push_expected(); stream(1'b1);
    wait_got(1);
    m_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    m_ready = 1'b1;
    wait_drained();
    lits(11, 22, 33, 44, 11, 22, 33, 44); check_lits("stall");

    // Reset during group 1 compute, then a fresh problem
    set_problem(0); push_expected(); stream(1'b0);
    wait_got(2);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_s_ready", if0.s_ready, 1);
    chk("midrst_m_valid", if0.m_valid, 0);
    set_problem(0); push_expected(); stream(1'b0); wait_drained();
    lits(11, 22, 33, 44, 11, 22, 33, 44); check_lits("after_reset");

    // Back-to-back problems
    set_problem(0); push_expected(); stream(1'b0);
    set_problem(3); push_expected(); stream(1'b0);
    wait_drained();
    chk("b2b_first_accept_gap", b2b_gap, 1);
    lits(11, 22, 33, 44, 11, 22, 33, 44);
    lits(2, 2, 2, 2, 2, 2, 2, 2);
    check_lits("back2back");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
